// File: rtl/fpmul_seq_if.sv
// Operand/product handshake bundle for fpmul_seq: operands in on a valid/ready pair,
// product out on a second valid/ready pair.
interface fpmul_seq_if #(
   parameter int LOG_BIT = 6
);
   localparam int W = 2 ** LOG_BIT;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, out
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, out
   );
endinterface

// File: rtl/fpmul_seq.sv
// Iterative IEEE-754 multiplier: shift-add significand product, one-cycle normalise,
// one-cycle round-to-nearest-even, with a fast path for NaN/inf/zero operands.
module fpmul_seq #(
   parameter int LOG_BIT = 6,
   parameter int EXP_BIT = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   fpmul_seq_if.slave bus,
   output logic       busy
);
   localparam int W       = 2 ** LOG_BIT;
   localparam int MAN_BIT = W - 1 - EXP_BIT;
   localparam int M       = MAN_BIT + 1;
   localparam int PW      = 2 * M;
   localparam int EW      = EXP_BIT + 2;
   localparam int IW      = LOG_BIT + 1;
   localparam int BIAS    = 2 ** (EXP_BIT - 1) - 1;

   localparam logic [EXP_BIT-1:0]   EXP_ONES  = '1;
   localparam logic [LOG_BIT-1:0]   CNT_LAST  = LOG_BIT'(MAN_BIT);
   localparam logic signed [EW-1:0] ONE_S     = EW'(1);
   localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
   localparam logic signed [EW-1:0] ZOFS_S    = EW'(2 * MAN_BIT);
   localparam logic signed [EW-1:0] EXP_MAX_S = EW'(2 ** EXP_BIT - 1);
   localparam logic signed [EW-1:0] DEN_LIM_S = EW'(MAN_BIT + 3);
   localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_BIT-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
   state_t state, state_nxt;

   logic [LOG_BIT-1:0]   cnt;
   logic [W-1:0]         res;

   logic                 sign_p0;
   logic [EXP_BIT-1:0]   exp_a_p0, exp_b_p0;
   logic [PW-1:0]        mcand_p0;
   logic [M-1:0]         mplier_p0;
   logic [PW-1:0]        prod_p0;

   logic [M-1:0]         sig_p1;
   logic                 guard_p1, rnd_p1, sticky_p1;
   logic signed [EW-1:0] exp_p1;

   logic [EXP_BIT-1:0]   ea, eb;
   logic [MAN_BIT-1:0]   fa, fb;
   logic                 sign_ab, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic                 special, accept;
   logic [W-1:0]         special_res;

   logic [IW-1:0]        lead;
   logic [PW-1:0]        norm_vec, den_vec;
   logic signed [EW-1:0] exp_raw, exp_n, den_sh;
   logic                 lost;

   function automatic logic [IW-1:0] lead_one(input logic [PW-1:0] v);
      lead_one = '0;
      for (int i = 0; i < PW; i++)
         if (v[i]) lead_one = IW'(i);
   endfunction

   // Nearest-even rounding of a normalised (or denormal, e==0) significand; saturates to inf.
   function automatic logic [W-1:0] round_pack(
      input logic                 s,
      input logic signed [EW-1:0] e,
      input logic [M-1:0]         sig,
      input logic                 g,
      input logic                 r,
      input logic                 st
   );
      logic                 up;
      logic [M:0]           sum;
      logic signed [EW-1:0] e_out;
      logic [MAN_BIT-1:0]   frac;
      up  = g & (r | st | sig[0]);
      sum = {1'b0, sig} + {{M{1'b0}}, up};
      if (e == '0) begin
         e_out = sum[MAN_BIT] ? ONE_S : '0;
         frac  = sum[MAN_BIT-1:0];
      end else if (sum[M]) begin
         e_out = e + ONE_S;
         frac  = sum[MAN_BIT:1];
      end else begin
         e_out = e;
         frac  = sum[MAN_BIT-1:0];
      end
      if (e_out >= EXP_MAX_S)
         round_pack = {s, EXP_ONES, {MAN_BIT{1'b0}}};
      else
         round_pack = {s, e_out[EXP_BIT-1:0], frac};
   endfunction

   assign ea      = bus.a[W-2 -: EXP_BIT];
   assign eb      = bus.b[W-2 -: EXP_BIT];
   assign fa      = bus.a[MAN_BIT-1:0];
   assign fb      = bus.b[MAN_BIT-1:0];
   assign sign_ab = bus.a[W-1] ^ bus.b[W-1];
   assign nan_a   = (ea == EXP_ONES) && (fa != '0);
   assign nan_b   = (eb == EXP_ONES) && (fb != '0);
   assign inf_a   = (ea == EXP_ONES) && (fa == '0);
   assign inf_b   = (eb == EXP_ONES) && (fb == '0);
   assign zero_a  = (ea == '0) && (fa == '0);
   assign zero_b  = (eb == '0) && (fb == '0);
   assign accept  = bus.in_valid && (state == IDLE);
   assign bus.out = res;

   always_comb begin
      special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
      if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a))
         special_res = QNAN;
      else if (inf_a | inf_b)
         special_res = {sign_ab, EXP_ONES, {MAN_BIT{1'b0}}};
      else
         special_res = {sign_ab, {(W-1){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
            if (bus.in_valid) state_nxt = special ? DONE : MUL;
         end
         MUL:   if (cnt == CNT_LAST) state_nxt = NORM;
         NORM:  state_nxt = ROUND;
         ROUND: state_nxt = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         res <= '0;
      end else begin
         if (accept) cnt <= '0;
         else if (state == MUL) cnt <= cnt + LOG_BIT'(1);
         if (accept && special) res <= special_res;
         else if (state == ROUND)
            res <= round_pack(sign_p0, exp_p1, sig_p1, guard_p1, rnd_p1, sticky_p1);
      end
   end

   // ---- stage p0: operand capture and shift-add significand product ----
   always_ff @(posedge clk) begin
      if (accept) begin
         sign_p0   <= sign_ab;
         exp_a_p0  <= (ea == '0) ? EXP_BIT'(1) : ea;
         exp_b_p0  <= (eb == '0) ? EXP_BIT'(1) : eb;
         mcand_p0  <= {{M{1'b0}}, ea != '0, fa};
         mplier_p0 <= {eb != '0, fb};
         prod_p0   <= '0;
      end else if (state == MUL) begin
         if (mplier_p0[0]) prod_p0 <= prod_p0 + mcand_p0;
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end

   // A leading one at index 2*MAN_BIT is the product 1.0 x 1.0, hence the ZOFS offset.
   always_comb begin
      lead     = lead_one(prod_p0);
      norm_vec = prod_p0 << (IW'(PW - 1) - lead);
      exp_raw  = $signed({2'b00, exp_a_p0}) + $signed({2'b00, exp_b_p0}) - BIAS_S
                 + $signed(EW'(lead)) - ZOFS_S;
      den_sh   = ONE_S - exp_raw;
      den_vec  = norm_vec;
      exp_n    = exp_raw;
      lost     = 1'b0;
      if (exp_raw < ONE_S) begin
         exp_n = '0;
         if (den_sh >= DEN_LIM_S) begin
            den_vec = '0;
            lost    = |norm_vec;
         end else begin
            den_vec = norm_vec >> den_sh[IW-1:0];
            lost    = (den_vec << den_sh[IW-1:0]) != norm_vec;
         end
      end
   end

   // ---- stage p1: normalised significand with guard/round/sticky ----
   always_ff @(posedge clk) begin
      if (state == NORM) begin
         sig_p1    <= den_vec[PW-1 -: M];
         guard_p1  <= den_vec[PW-1-M];
         rnd_p1    <= den_vec[PW-2-M];
         sticky_p1 <= (|den_vec[PW-3-M:0]) | lost;
         exp_p1    <= exp_n;
      end
   end
endmodule

// File: tb/tb_fpmul_seq.sv
// Randomised and directed bench for fpmul_seq (double precision), scored against the
// simulator's real multiply with NaN results mapped to the canonical quiet NaN.
module tb_fpmul_seq;
   localparam int          LOG_BIT = 6;
   localparam int          EXP_BIT = 11;
   localparam int          MAN_BIT = 52;
   localparam logic [63:0] QNAN    = 64'h7FF8000000000000;
   localparam logic [63:0] ONE     = 64'h3FF0000000000000;
   localparam logic [63:0] TWO     = 64'h4000000000000000;
   localparam logic [63:0] HALF    = 64'h3FE0000000000000;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   n_tests = 0;
   int   n_fail  = 0;

   fpmul_seq_if #(.LOG_BIT(LOG_BIT)) bus ();

   fpmul_seq #(.LOG_BIT(LOG_BIT), .EXP_BIT(EXP_BIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic bit is_nan(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
   endfunction

   function automatic bit is_special(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) || (x[62:0] == 63'd0);
   endfunction

   function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r;
      if (is_nan(x) || is_nan(y)) return QNAN;
      r = $realtobits($bitstoreal(x) * $bitstoreal(y));
      if (is_nan(r)) return QNAN;
      return r;
   endfunction

   function automatic logic [63:0] rand_operand();
      logic        s;
      logic [10:0] e;
      logic [51:0] f;
      s = 1'($urandom);
      f = {20'($urandom), $urandom};
      case ($urandom_range(0, 11))
         0:       begin e = 11'd0; f = 52'd0; end
         1, 2:    e = 11'd0;
         3:       begin e = 11'h7FF; f = 52'd0; end
         4:       e = 11'h7FF;
         5:       e = 11'($urandom_range(1900, 2046));
         6:       e = 11'($urandom_range(1, 150));
         7:       begin e = 11'd1023; f = 52'($urandom_range(0, 3)); end
         default: e = 11'($urandom_range(1, 2046));
      endcase
      return {s, e, f};
   endfunction

   task automatic issue(input logic [63:0] ta, input logic [63:0] tb_v);
      bus.in_valid = 1'b1;
      bus.a        = ta;
      bus.b        = tb_v;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic await_out(output logic [63:0] res, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      res = bus.out;
   endtask

   task automatic release_out();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                        input logic [63:0] exp_v);
      logic [63:0] res;
      int          lat;
      int          exp_lat;
      exp_lat = (is_special(ta) || is_special(tb_v)) ? 0 : MAN_BIT + 3;
      issue(ta, tb_v);
      await_out(res, lat);
      check_val({tag, " out"}, res, exp_v);
      check_val({tag, " latency"}, 64'(lat), 64'(exp_lat));
      release_out();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] res, ra, rb;
      int          lat;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b1;
      #2 rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst out", bus.out, 64'd0);
      check_val("rst out_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst in_ready", 64'(bus.in_ready), 64'd1);

      do_op("1x2", ONE, TWO, 64'h4000000000000000);
      do_op("3xm05", 64'h4008000000000000, 64'hBFE0000000000000, 64'hBFF8000000000000);
      do_op("pinf_x0", 64'h7FF0000000000000, 64'd0, 64'h7FF8000000000000);
      do_op("ninf_x2", 64'hFFF0000000000000, TWO, 64'hFFF0000000000000);
      do_op("nan_xinf", 64'h7FF4000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000);
      do_op("zero_xneg", 64'd0, 64'hBFF0000000000000, 64'h8000000000000000);
      do_op("max_x2", 64'h7FEFFFFFFFFFFFFF, TWO, 64'h7FF0000000000000);
      do_op("ulp_sq", 64'h3FF0000000000001, 64'h3FF0000000000001, 64'h3FF0000000000002);
      do_op("den1_x05", 64'h0000000000000001, HALF, 64'h0000000000000000);
      do_op("den3_x05", 64'h0000000000000003, HALF, 64'h0000000000000002);
      do_op("minn_x05", 64'h0010000000000000, HALF, 64'h0008000000000000);

      // Backpressure: operands offered while busy must not be taken.
      issue(ONE, TWO);
      repeat (5) begin
         bus.in_valid = 1'b1;
         bus.a        = rand_operand();
         bus.b        = rand_operand();
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      await_out(res, lat);
      check_val("hold out", res, 64'h4000000000000000);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = rand_operand();
         bus.b        = rand_operand();
         @(negedge clk);
         check_val($sformatf("hold%0d out_valid", i), 64'(bus.out_valid), 64'd1);
         check_val($sformatf("hold%0d out", i), bus.out, 64'h4000000000000000);
         check_val($sformatf("hold%0d in_ready", i), 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
      release_out();
      check_val("drain out_valid", 64'(bus.out_valid), 64'd0);
      check_val("drain in_ready", 64'(bus.in_ready), 64'd1);
      check_val("drain busy", 64'(busy), 64'd0);

      // Asynchronous reset in the middle of the shift-add phase.
      issue(ONE, TWO);
      repeat (20) @(negedge clk);
      check_val("midop busy", 64'(busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("midop rst out_valid", 64'(bus.out_valid), 64'd0);
      check_val("midop rst busy", 64'(busy), 64'd0);
      check_val("midop rst out", bus.out, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("midop in_ready", 64'(bus.in_ready), 64'd1);
      do_op("post_rst 1x2", ONE, TWO, 64'h4000000000000000);

      for (int i = 0; i < 150; i++) begin
         ra = rand_operand();
         rb = rand_operand();
         do_op($sformatf("rnd%0d %h*%h", i, ra, rb), ra, rb, ref_mul(ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
